// File: rtl/inst_fetch_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_resp_pkg
//  Description : Shared types and constants for the instruction fetch
//                responder: FSM state encoding, the NOP returned on reset
//                and on faulting lines, and line-geometry helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_resp_pkg;

    // Responder FSM: IDLE does lookups, REQ holds the line request on the
    // bus until accepted, WAIT waits for the single-beat line response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_resp_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Full-width line tag: a byte address with the in-line offset bits zeroed.
    typedef logic [63:0] line_tag_t;

    // Number of byte-offset bits inside one line.
    function automatic int line_off_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

endpackage : inst_fetch_resp_pkg
`default_nettype wire

// File: rtl/inst_fetch_resp_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_resp_if
//  Description : Instruction-side line-read bus. One request channel
//                (valid/ready + line address) and one single-beat response
//                channel (valid + whole line + error).
//  Modports    : master - the fetch responder (drives requests)
//                slave  - the memory / bus arbiter (drives responses)
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_resp_if #(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 8
);
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [ADDR_W-1:0]       mem_req_addr;
    logic                    mem_resp_valid;
    logic [LINE_BYTES*8-1:0] mem_resp_data;
    logic                    mem_resp_err;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        input  mem_resp_err
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        output mem_resp_err
    );

endinterface : inst_fetch_resp_if
`default_nettype wire

// File: rtl/inst_fetch_resp_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : inst_line_buf
//  Description : One-line fetch buffer. Holds the tag, valid bit and data of
//                the most recently filled line, compares the lookup line
//                against the tag and selects the addressed 32-bit word.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                lookup_line_i   - line-aligned lookup address
//                word_idx_i      - word index within the line
//                fill_en_i       - write a new line this cycle
//                fill_line_i     - line-aligned address of the new line
//                fill_data_i     - new line data, little-endian
//                hit_o           - buffer valid and tag matches
//                word_o          - selected word (meaningful only on hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_line_buf
    import inst_fetch_resp_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 8
) (
    input  wire logic                                     clk,
    input  wire logic                                     rst,
    input  wire logic [ADDR_W-1:0]                        lookup_line_i,
    input  wire logic [line_off_bits(LINE_BYTES)-3:0]     word_idx_i,
    input  wire logic                                     fill_en_i,
    input  wire logic [ADDR_W-1:0]                        fill_line_i,
    input  wire logic [LINE_BYTES*8-1:0]                  fill_data_i,
    output logic                                          hit_o,
    output logic [31:0]                                   word_o
);

    logic                    valid_q;
    logic [ADDR_W-1:0]       tag_q;
    logic [LINE_BYTES*8-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_en_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_line_i;
            data_q  <= fill_data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_line_i);
    // Word w occupies bits [32*w +: 32] of the little-endian line.
    assign word_o = data_q[{word_idx_i, 5'b0} +: 32];

endmodule : inst_line_buf
`default_nettype wire

// File: rtl/inst_fetch_resp.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_resp
//  Description : IF-stage instruction port responder with SRAM-like 1-cycle
//                timing. Hits are served from a one-line buffer; a miss
//                fetches the whole line over the valid/ready memory bus and
//                holds inst_busy high until the held address is re-looked-up.
//                A line that returned a bus error is remembered as the fault
//                line and answered with NOP + inst_fault, without refetch,
//                until a different line is looked up.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                inst_ena     - fetch request this cycle
//                inst_addra   - fetch address (bits [1:0] ignored)
//                inst_douta   - instruction for the previously sampled address
//                inst_busy    - inst_douta not valid, IF must hold its address
//                inst_fault   - returned instruction came from a faulting line
//                mem          - line-read bus (master side)
//                perf_hit_cnt, perf_miss_cnt - saturating event counters,
//                               present only with INST_FETCH_PERF_EN defined
//  Config      : INST_FETCH_PERF_EN - adds the performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int LINE_BYTES = 8,
    parameter int ADDR_W     = 64
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               inst_ena,
    input  wire logic [ADDR_W-1:0]  inst_addra,
    output logic [31:0]             inst_douta,
    output logic                    inst_busy,
    output logic                    inst_fault,
    inst_fetch_resp_if.master       mem
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [63:0]             perf_hit_cnt,
    output logic [63:0]             perf_miss_cnt
`endif
);

    localparam int OFF_W = line_off_bits(LINE_BYTES);
    localparam int IDX_W = OFF_W - 2;

    fetch_resp_state_t  state_q;
    logic               busy_q;
    logic [31:0]        douta_q;
    logic               fault_q;
    logic               req_valid_q;
    logic [ADDR_W-1:0]  miss_line_q;
    logic [ADDR_W-1:0]  fault_line_q;
    logic               fault_valid_q;

    logic [ADDR_W-1:0]  addr_line;
    logic [IDX_W-1:0]   word_idx;
    logic               buf_hit;
    logic [31:0]        buf_word;
    logic               buf_fill_en;
    logic               fault_hit;
    logic               unused_addr_lsbs;

    assign addr_line        = {inst_addra[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign word_idx         = inst_addra[OFF_W-1:2];
    assign unused_addr_lsbs = ^inst_addra[1:0];

    assign fault_hit   = fault_valid_q && (fault_line_q == addr_line);
    assign buf_fill_en = (state_q == WAIT) && mem.mem_resp_valid && !mem.mem_resp_err;

    inst_line_buf #(
        .ADDR_W     (ADDR_W),
        .LINE_BYTES (LINE_BYTES)
    ) u_line_buf (
        .clk           (clk),
        .rst           (rst),
        .lookup_line_i (addr_line),
        .word_idx_i    (word_idx),
        .fill_en_i     (buf_fill_en),
        .fill_line_i   (miss_line_q),
        .fill_data_i   (mem.mem_resp_data),
        .hit_o         (buf_hit),
        .word_o        (buf_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            douta_q       <= NOP_INSTR;
            fault_q       <= 1'b0;
            req_valid_q   <= 1'b0;
            miss_line_q   <= '0;
            fault_line_q  <= '0;
            fault_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inst_ena) begin
                        if (fault_hit) begin
                            // Known-bad line: answer without going back to memory.
                            douta_q <= NOP_INSTR;
                            fault_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            // Moving to another line forgets the fault record,
                            // so a later return to the bad line retries it.
                            fault_valid_q <= 1'b0;
                            if (buf_hit) begin
                                douta_q <= buf_word;
                                fault_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end else begin
                                busy_q      <= 1'b1;
                                miss_line_q <= addr_line;
                                req_valid_q <= 1'b1;
                                state_q     <= REQ;
                            end
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    // busy stays high: the following IDLE cycle re-looks-up
                    // whatever address IF is presenting by then.
                    if (mem.mem_resp_valid) begin
                        if (mem.mem_resp_err) begin
                            fault_line_q  <= miss_line_q;
                            fault_valid_q <= 1'b1;
                        end else if (fault_line_q == miss_line_q) begin
                            fault_valid_q <= 1'b0;
                        end
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inst_douta        = douta_q;
    assign inst_busy         = busy_q;
    assign inst_fault        = fault_q;
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = miss_line_q;

`ifdef INST_FETCH_PERF_EN
    logic [63:0] hit_cnt_q;
    logic [63:0] miss_cnt_q;
    logic        lookup;

    assign lookup = (state_q == IDLE) && inst_ena;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup && (fault_hit || buf_hit) && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 64'd1;
            end
            if (lookup && !fault_hit && !buf_hit && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 64'd1;
            end
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule : inst_fetch_resp
`default_nettype wire

// File: tb/tb_inst_fetch_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_resp
//  Description : Self-checking bench for inst_fetch_resp: directed sequences,
//                a single-cycle vector table on the hit path, and a random
//                phase compared against a line-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inst_fetch_resp;

    localparam int ADDR_W = 64;
    localparam int LB     = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              inst_ena = 1'b0;
    logic [ADDR_W-1:0] inst_addra = '0;
    logic [31:0]       inst_douta;
    logic              inst_busy;
    logic              inst_fault;

    inst_fetch_resp_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LB)) bus ();

`ifdef INST_FETCH_PERF_EN
    logic [63:0] perf_hit_cnt;
    logic [63:0] perf_miss_cnt;
`endif

    inst_fetch_resp #(.LINE_BYTES(LB), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_ena   (inst_ena),
        .inst_addra (inst_addra),
        .inst_douta (inst_douta),
        .inst_busy  (inst_busy),
        .inst_fault (inst_fault),
        .mem        (bus.master)
`ifdef INST_FETCH_PERF_EN
        ,
        .perf_hit_cnt  (perf_hit_cnt),
        .perf_miss_cnt (perf_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory side: manual drive for the first directed steps, automatic
    // responder afterwards.
    logic        auto_mem = 1'b0;
    logic        m_ready = 1'b0, m_rv = 1'b0, m_err = 1'b0;
    logic [63:0] m_data = '0;
    logic        a_ready, a_rv, a_err;
    logic [63:0] a_data;
    int          rdy_pct = 100, dly_min = 0, dly_span = 0;
    logic        spur_en = 1'b0, force_err = 1'b0;

    assign bus.mem_req_ready  = auto_mem ? a_ready : m_ready;
    assign bus.mem_resp_valid = auto_mem ? a_rv    : m_rv;
    assign bus.mem_resp_data  = auto_mem ? a_data  : m_data;
    assign bus.mem_resp_err   = auto_mem ? a_err   : m_err;

    int checks = 0;
    int failures = 0;

    int          req_cnt = 0;
    logic [63:0] last_req_addr = '0;

    always @(posedge clk) begin
        if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
            req_cnt       <= req_cnt + 1;
            last_req_addr <= bus.mem_req_addr;
        end
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] & 32'hFFFF_FFFC) ^ 32'hA5A5_0003;
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction

    function automatic logic err_line(input logic [63:0] l);
        return force_err || ((l[63:12] == 52'h1) && (l[5:3] == 3'd5));
    endfunction

    initial begin : mem_model
        bit          pend;
        int          dly;
        logic [63:0] paddr;
        pend = 0; dly = 0; paddr = '0;
        a_ready = 1'b0; a_rv = 1'b0; a_err = 1'b0; a_data = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                pend = 0;
            end else begin
                if (pend && a_rv && auto_mem) pend = 0;
                if (auto_mem && a_ready && bus.mem_req_valid) begin
                    pend  = 1;
                    paddr = bus.mem_req_addr;
                    dly   = dly_min + int'($urandom_range(0, dly_span));
                end
            end
            @(negedge clk);
            a_rv = 1'b0; a_err = 1'b0; a_data = {$urandom, $urandom};
            if (pend) begin
                if (dly == 0) begin
                    a_rv  = 1'b1;
                    a_err = err_line(paddr);
                    if (!a_err) a_data = {mem_word(paddr + 64'd4), mem_word(paddr)};
                end else begin
                    dly--;
                end
            end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
                a_rv  = 1'b1;
                a_err = 1'($urandom_range(0, 1));
            end
            a_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fetch_and_wait(input logic [63:0] a);
        int n;
        inst_ena   = 1'b1;
        inst_addra = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (inst_busy && n < 200);
        if (inst_busy) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout addr=%h busy=%b required=0", a, inst_busy);
        end
    endtask

    task automatic wait_req(input int target);
        int n;
        n = 0;
        while (req_cnt < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (req_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL req_timeout count=%0d required=%0d", req_cnt, target);
        end
    endtask

    typedef struct {
        logic        ena;
        logic [63:0] addr;
        logic [31:0] douta;
        logic        busy;
        logic        fault;
    } vec_t;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        tbl[5];
        logic [63:0] mb_line, mf_line, a, l;
        logic        mb_valid, mf_valid, exp_fault;
        logic [31:0] exp_douta;
        int          exp_req, c0;

        tbl[0] = '{1'b1, 64'h8000_0004, 32'h0000_0093, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 64'h8000_0004, 32'h0000_0013, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 64'h8000_0004, 32'h0000_0093, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 64'h8000_0010, 32'h0000_0093, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_douta", 64'(inst_douta), 64'(NOP));
        chk("reset_busy", 64'(inst_busy), 64'd0);
        chk("reset_fault", 64'(inst_fault), 64'd0);
        chk("reset_req_valid", 64'(bus.mem_req_valid), 64'd0);

        // First miss with minimum latency
        rst = 1'b0; inst_ena = 1'b1; inst_addra = 64'h8000_0000; m_ready = 1'b1;
        @(negedge clk);
        chk("miss_busy_e1", 64'(inst_busy), 64'd1);
        chk("miss_req_valid_e1", 64'(bus.mem_req_valid), 64'd1);
        chk("miss_req_addr_e1", bus.mem_req_addr, 64'h8000_0000);
        @(negedge clk);
        chk("miss_req_cnt_e2", 64'(req_cnt), 64'd1);
        chk("miss_req_valid_e2", 64'(bus.mem_req_valid), 64'd0);
        m_ready = 1'b0; m_rv = 1'b1; m_data = 64'h0000_0093_0000_0013;
        @(negedge clk);
        chk("miss_busy_e3", 64'(inst_busy), 64'd1);
        m_rv = 1'b0;
        @(negedge clk);
        chk("miss_busy_e4", 64'(inst_busy), 64'd0);
        chk("miss_douta_e4", 64'(inst_douta), 64'h13);
        chk("miss_fault_e4", 64'(inst_fault), 64'd0);

        // Hit path vectors, ending with a miss on a new line
        for (int i = 0; i < 5; i++) begin
            inst_ena = tbl[i].ena; inst_addra = tbl[i].addr;
            @(negedge clk);
            chk($sformatf("vec%0d_douta", i), 64'(inst_douta), 64'(tbl[i].douta));
            chk($sformatf("vec%0d_busy", i), 64'(inst_busy), 64'(tbl[i].busy));
            chk($sformatf("vec%0d_fault", i), 64'(inst_fault), 64'(tbl[i].fault));
        end
        chk("vec_no_extra_req", 64'(req_cnt), 64'd1);

        // Request held while ready stays low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", i), 64'(bus.mem_req_valid), 64'd1);
            chk($sformatf("stall%0d_addr", i), bus.mem_req_addr, 64'h8000_0010);
            chk($sformatf("stall%0d_busy", i), 64'(inst_busy), 64'd1);
        end
        chk("stall_req_cnt", 64'(req_cnt), 64'd1);
        m_ready = 1'b1;
        @(negedge clk);
        chk("stall_single_req", 64'(req_cnt), 64'd2);
        chk("stall_valid_drop", 64'(bus.mem_req_valid), 64'd0);
        m_ready = 1'b0; m_rv = 1'b1; m_data = 64'h1111_2222_3333_4444;
        @(negedge clk);
        m_rv = 1'b0;
        @(negedge clk);
        chk("stall_douta", 64'(inst_douta), 64'h3333_4444);
        chk("stall_busy", 64'(inst_busy), 64'd0);

        // Fault line handling
        auto_mem = 1'b1; rdy_pct = 100; dly_min = 0; dly_span = 0;
        force_err = 1'b1;
        fetch_and_wait(64'h8000_0000);
        chk("fault_douta", 64'(inst_douta), 64'(NOP));
        chk("fault_flag", 64'(inst_fault), 64'd1);
        chk("fault_req_cnt", 64'(req_cnt), 64'd3);
        chk("fault_req_addr", last_req_addr, 64'h8000_0000);
        force_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("fault_hold%0d", i), 64'({inst_busy, inst_fault}), 64'b01);
        end
        chk("fault_no_refetch", 64'(req_cnt), 64'd3);
        fetch_and_wait(64'h8000_0008);
        chk("fault_clear", 64'(inst_fault), 64'd0);
        chk("fault_next_req", last_req_addr, 64'h8000_0008);
        chk("fault_next_douta", 64'(inst_douta), 64'(mem_word(64'h8000_0008)));
        chk("fault_next_cnt", 64'(req_cnt), 64'd4);

        // Redirect while waiting for a fill
        dly_min = 2;
        inst_ena = 1'b1; inst_addra = 64'h100;
        wait_req(5);
        inst_addra = 64'h200;
        fetch_and_wait(64'h200);
        chk("redir_douta", 64'(inst_douta), 64'(mem_word(64'h200)));
        chk("redir_req_cnt", 64'(req_cnt), 64'd6);
        chk("redir_req_addr", last_req_addr, 64'h200);

        // Reset during WAIT
        dly_min = 5;
        inst_ena = 1'b1; inst_addra = 64'h300;
        wait_req(7);
        rst = 1'b1; inst_ena = 1'b0;
        @(negedge clk);
        chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_busy", 64'(inst_busy), 64'd0);
        chk("rst_douta", 64'(inst_douta), 64'(NOP));
        rst = 1'b0;
        @(negedge clk);
        dly_min = 0;
        c0 = req_cnt;
        fetch_and_wait(64'h200);
        chk("rst_refetch_miss", 64'(req_cnt - c0), 64'd1);
        chk("rst_refetch_douta", 64'(inst_douta), 64'(mem_word(64'h200)));

        // Random phase against a line-level model
        rdy_pct = 50; dly_min = 0; dly_span = 3; spur_en = 1'b1;
        mb_line = 64'h200; mb_valid = 1'b1; mf_line = '0; mf_valid = 1'b0;
        exp_douta = mem_word(64'h200); exp_fault = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                inst_ena = 1'b0;
                inst_addra = 64'h1000 + 64'($urandom_range(0, 15)) * 64'd4;
                @(negedge clk);
                chk($sformatf("rnd%0d_idle", i),
                    {31'd0, inst_busy, inst_fault, inst_douta},
                    {31'd0, 1'b0, exp_fault, exp_douta});
            end else begin
                a = 64'h1000 + 64'($urandom_range(0, 15)) * 64'd4;
                l = line_of(a);
                if (mf_valid && mf_line == l) begin
                    exp_req = 0; exp_douta = NOP; exp_fault = 1'b1;
                end else begin
                    mf_valid = 1'b0;
                    if (mb_valid && mb_line == l) begin
                        exp_req = 0; exp_douta = mem_word(a); exp_fault = 1'b0;
                    end else begin
                        exp_req = 1;
                        if (err_line(l)) begin
                            mf_line = l; mf_valid = 1'b1;
                            exp_douta = NOP; exp_fault = 1'b1;
                        end else begin
                            mb_line = l; mb_valid = 1'b1;
                            exp_douta = mem_word(a); exp_fault = 1'b0;
                        end
                    end
                end
                c0 = req_cnt;
                fetch_and_wait(a);
                chk($sformatf("rnd%0d_douta a=%h", i, a), 64'(inst_douta), 64'(exp_douta));
                chk($sformatf("rnd%0d_fault", i), 64'(inst_fault), 64'(exp_fault));
                chk($sformatf("rnd%0d_reqs", i), 64'(req_cnt - c0), 64'(exp_req));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_inst_fetch_resp
`default_nettype wire
